// File: rtl/wb_timer_bank_if.sv
// wb_timer_bank_if
//   Pipelined Wishbone slave bundle used by the wb_timer_bank peripheral.
//   The signal names keep the i_/o_ direction prefixes as seen from the slave.
//   Signals:
//     i_wb_cyc    bus cycle valid          (master -> slave)
//     i_wb_stb    strobe                   (master -> slave)
//     i_wb_we     1 = write                (master -> slave)
//     i_wb_addr   word address             (master -> slave)
//     i_wb_data   write data               (master -> slave)
//     o_wb_ack    transfer acknowledge     (slave -> master)
//     o_wb_stall  pipeline stall, always 0 (slave -> master)
//     o_wb_data   read data, valid with ack (slave -> master)
interface wb_timer_bank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  i_wb_cyc;
  logic                  i_wb_stb;
  logic                  i_wb_we;
  logic [ADDR_WIDTH-1:0] i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;
  logic                  o_wb_ack;
  logic                  o_wb_stall;
  logic [DATA_WIDTH-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_timer_bank.sv
// wb_timer_bank
//   Multi-channel Wishbone timer bank. Each of NUM_CH channels has a
//   prescaler, a counter, a compare register, auto-reload / one-shot mode
//   and a sticky match flag; enabled flags are OR-ed onto o_irq.
//   Register map (word addresses), channel c at base 8*c:
//     +0 CTRL (bit0 EN, bit1 ONESHOT, bit2 IE), +1 PRESC, +2 COUNT,
//     +3 CMP, +4 CAPT, +5..+7 reserved.
//   STATUS at 8*NUM_CH: [NUM_CH-1:0] match flags, [2*NUM_CH-1:NUM_CH]
//   capture flags, both write-one-to-clear.
//   Optional feature macro: WB_TIMER_CAPTURE_EN adds the i_capture input
//   and the capture registers/flags; without it CAPT and capture flags read 0.
//   Ports:
//     i_clk      system clock
//     i_rst      synchronous active-high reset
//     wb         Wishbone slave (wb_timer_bank_if.slave)
//     i_capture  per-channel capture inputs (only with WB_TIMER_CAPTURE_EN)
//     o_irq      OR over channels of (match flag & IE)
//     o_count    live counts, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
module wb_timer_bank #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  wb_timer_bank_if.slave               wb,
`ifdef WB_TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0]            i_capture,
`endif
  output logic                         o_irq,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_count
);

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(8 * NUM_CH);

  // Channel state
  logic [2:0]             r_ctrl  [NUM_CH];
  logic [PRESC_WIDTH-1:0] r_presc [NUM_CH];
  logic [PRESC_WIDTH-1:0] r_pcnt  [NUM_CH];
  logic [DATA_WIDTH-1:0]  r_count [NUM_CH];
  logic [DATA_WIDTH-1:0]  r_cmp   [NUM_CH];
  logic [NUM_CH-1:0]      r_match;

  // Bus-side registers
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Decode and per-channel combinational signals
  logic                  w_acc;
  logic                  w_wr;
  logic [2:0]            w_off;
  logic [ADDR_WIDTH-4:0] w_ch_sel;
  logic                  w_is_status;
  logic [NUM_CH-1:0]     w_ch_hit;
  logic [NUM_CH-1:0]     w_tick;
  logic [NUM_CH-1:0]     w_match_set;
  logic [NUM_CH-1:0]     w_match_clr;
  logic [NUM_CH-1:0]     w_ie;
  logic [DATA_WIDTH-1:0] w_ch_rd [NUM_CH];
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata;

`ifdef WB_TIMER_CAPTURE_EN
  logic [NUM_CH-1:0]     r_cap_meta;
  logic [NUM_CH-1:0]     r_cap_sync;
  logic [NUM_CH-1:0]     r_cap_prev;
  logic [NUM_CH-1:0]     r_cflag;
  logic [DATA_WIDTH-1:0] r_capt [NUM_CH];
  logic [NUM_CH-1:0]     w_cap_rise;
  logic [NUM_CH-1:0]     w_cap_clr;
`endif

  assign w_acc       = wb.i_wb_cyc & wb.i_wb_stb;
  assign w_wr        = w_acc & wb.i_wb_we;
  assign w_off       = wb.i_wb_addr[2:0];
  assign w_ch_sel    = wb.i_wb_addr[ADDR_WIDTH-1:3];
  assign w_is_status = (wb.i_wb_addr == STATUS_ADDR);

  assign wb.o_wb_ack   = r_ack;
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_data  = r_rdata;

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
      // Channel select only matches real channels, so STATUS/unmapped never alias.
      assign w_ch_hit[gc]    = (w_ch_sel == (ADDR_WIDTH-3)'(gc));
      assign w_tick[gc]      = r_ctrl[gc][CTRL_EN] & (r_pcnt[gc] == r_presc[gc]);
      // Match is judged on the pre-increment count of a tick.
      assign w_match_set[gc] = w_tick[gc] & (r_count[gc] == r_cmp[gc]);
      assign w_ie[gc]        = r_ctrl[gc][CTRL_IE];
      assign o_count[gc*DATA_WIDTH +: DATA_WIDTH] = r_count[gc];
    end
  endgenerate

  assign o_irq = |(r_match & w_ie);

  // W1C mask for the match flags from a STATUS write
  always_comb begin
    if (w_wr && w_is_status) begin
      w_match_clr = wb.i_wb_data[NUM_CH-1:0];
    end else begin
      w_match_clr = '0;
    end
  end

  // Per-channel read value for the addressed register offset
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_ch_rd[c] = '0;
      case (w_off)
        3'd0:    w_ch_rd[c] = DATA_WIDTH'(r_ctrl[c]);
        3'd1:    w_ch_rd[c] = DATA_WIDTH'(r_presc[c]);
        3'd2:    w_ch_rd[c] = r_count[c];
        3'd3:    w_ch_rd[c] = r_cmp[c];
`ifdef WB_TIMER_CAPTURE_EN
        3'd4:    w_ch_rd[c] = r_capt[c];
`endif
        default: w_ch_rd[c] = '0;
      endcase
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status = '0;
    w_status[NUM_CH-1:0] = r_match;
`ifdef WB_TIMER_CAPTURE_EN
    w_status[2*NUM_CH-1:NUM_CH] = r_cflag;
`endif
  end

  // Final read mux; selects are mutually exclusive so an OR tree suffices
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_rdata = w_rdata | (w_ch_hit[c] ? w_ch_rd[c] : '0);
    end
    w_rdata = w_rdata | (w_is_status ? w_status : '0);
  end

  // Bus response: ack one cycle after accept, data sampled before the write lands
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) begin
        r_rdata <= w_rdata;
      end
    end
  end

  // Channel counters and register writes; bus writes are last so they win
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_ctrl[c]  <= 3'd0;
        r_presc[c] <= '0;
        r_pcnt[c]  <= '0;
        r_count[c] <= '0;
        r_cmp[c]   <= '1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_tick[c]) begin
          r_pcnt[c] <= '0;
          if (w_match_set[c]) begin
            r_count[c] <= '0;
            if (r_ctrl[c][CTRL_ONESHOT]) begin
              r_ctrl[c][CTRL_EN] <= 1'b0;
            end
          end else begin
            r_count[c] <= r_count[c] + DATA_WIDTH'(1);
          end
        end else if (r_ctrl[c][CTRL_EN]) begin
          r_pcnt[c] <= r_pcnt[c] + PRESC_WIDTH'(1);
        end

        if (w_wr && w_ch_hit[c]) begin
          case (w_off)
            3'd0: r_ctrl[c] <= wb.i_wb_data[2:0];
            3'd1: begin
              r_presc[c] <= wb.i_wb_data[PRESC_WIDTH-1:0];
              r_pcnt[c]  <= '0;
            end
            3'd2: r_count[c] <= wb.i_wb_data;
            3'd3: r_cmp[c]   <= wb.i_wb_data;
            default: ;
          endcase
        end
      end
    end
  end

  // Sticky match flags; a same-cycle hardware set beats the W1C clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_match <= '0;
    end else begin
      r_match <= (r_match & ~w_match_clr) | w_match_set;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  assign w_cap_rise = r_cap_sync & ~r_cap_prev;

  // W1C mask for the capture flags from a STATUS write
  always_comb begin
    if (w_wr && w_is_status) begin
      w_cap_clr = wb.i_wb_data[2*NUM_CH-1:NUM_CH];
    end else begin
      w_cap_clr = '0;
    end
  end

  // Capture synchroniser, edge detect, capture registers and flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_meta <= '0;
      r_cap_sync <= '0;
      r_cap_prev <= '0;
      r_cflag    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_capt[c] <= '0;
      end
    end else begin
      r_cap_meta <= i_capture;
      r_cap_sync <= r_cap_meta;
      r_cap_prev <= r_cap_sync;
      r_cflag    <= (r_cflag & ~w_cap_clr) | w_cap_rise;
      for (int c = 0; c < NUM_CH; c++) begin
        // r_count is the pre-tick value when a tick lands on the same edge
        if (w_cap_rise[c]) begin
          r_capt[c] <= r_count[c];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_timer_bank.sv
// tb_wb_timer_bank
//   Directed self-checking bench for wb_timer_bank (NUM_CH=4, 8-bit word
//   addresses, 32-bit data). Bus requests are driven on the falling edge and
//   results sampled 1 ns after the rising edge. Expected values are worked
//   out by hand from the register map and tick/match rules.
module tb_wb_timer_bank;
  localparam int NUM_CH = 4;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int PW     = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 irq;
  logic [NUM_CH*DW-1:0] count;
`ifdef WB_TIMER_CAPTURE_EN
  logic [NUM_CH-1:0]    cap;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] dummy;

  wb_timer_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_timer_bank #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRESC_WIDTH(PW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .wb       (bus),
`ifdef WB_TIMER_CAPTURE_EN
    .i_capture(cap),
`endif
    .o_irq    (irq),
    .o_count  (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] cnt(input int c);
    return count[c*DW +: DW];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single request; returns just after the accept edge with ack checked.
  task automatic xfer(input string tag, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output logic [DW-1:0] rdata);
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = wdata;
    @(posedge clk);
    #1;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    check({"ack ", tag}, DW'(bus.o_wb_ack), 32'd1);
    rdata = bus.o_wb_data;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic [DW-1:0] d;
    xfer("wr", 1'b1, addr, wdata, d);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    xfer(tag, 1'b0, addr, 32'd0, d);
    check(tag, d, exp);
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 8'h00;
    bus.i_wb_data = 32'd0;
`ifdef WB_TIMER_CAPTURE_EN
    cap = 4'b0000;
`endif
    dummy = 32'd0;
    cycles(3);
    rst = 1'b0;

    // Reset state
    check("rst ack",   DW'(bus.o_wb_ack), 32'd0);
    check("rst rdata", bus.o_wb_data, 32'd0);
    check("rst irq",   DW'(irq), 32'd0);
    check("rst cnt0",  cnt(0), 32'd0);
    rd_chk("rst ctrl0",  8'h00, 32'h0000_0000);
    rd_chk("rst presc0", 8'h01, 32'h0000_0000);
    rd_chk("rst count0", 8'h02, 32'h0000_0000);
    rd_chk("rst cmp0",   8'h03, 32'hFFFF_FFFF);
    rd_chk("rst capt0",  8'h04, 32'h0000_0000);
    rd_chk("rst cmp3",   8'h1B, 32'hFFFF_FFFF);
    rd_chk("rst status", 8'h20, 32'h0000_0000);

    // Ch0: PRESC=3, CMP=4, EN+IE -> match on the 20th edge after enabling
    wr(8'h01, 32'd3);
    wr(8'h03, 32'd4);
    wr(8'h00, 32'h5);
    cycles(19);
    check("ch0 cnt e19", cnt(0), 32'd4);
    check("ch0 irq e19", DW'(irq), 32'd0);
    cycles(1);
    check("ch0 cnt e20", cnt(0), 32'd0);
    check("ch0 irq e20", DW'(irq), 32'd1);
    rd_chk("ch0 status", 8'h20, 32'h0000_0001);
    rd_chk("ch0 count",  8'h02, 32'd0);
    wr(8'h20, 32'h1);
    check("ch0 irq w1c", DW'(irq), 32'd0);
    rd_chk("ch0 status w1c", 8'h20, 32'h0000_0000);
    wr(8'h00, 32'h0);
    rd_chk("ch0 frozen", 8'h02, 32'd1);

    // Ch1: PRESC=0, CMP=2, EN+ONESHOT -> stops after 3 ticks
    wr(8'h0B, 32'd2);
    wr(8'h08, 32'h3);
    cycles(2);
    check("ch1 cnt t2", cnt(1), 32'd2);
    cycles(1);
    check("ch1 cnt t3", cnt(1), 32'd0);
    check("ch1 irq", DW'(irq), 32'd0);
    cycles(3);
    check("ch1 stays", cnt(1), 32'd0);
    rd_chk("ch1 ctrl", 8'h08, 32'h0000_0002);
    rd_chk("ch1 status", 8'h20, 32'h0000_0002);
    wr(8'h20, 32'h2);
    rd_chk("ch1 status w1c", 8'h20, 32'h0000_0000);

    // Ch2: wrap from all-ones to zero with no flag
    wr(8'h13, 32'd5);
    wr(8'h12, 32'hFFFF_FFFE);
    wr(8'h10, 32'h1);
    cycles(1);
    check("ch2 cnt t1", cnt(2), 32'hFFFF_FFFF);
    cycles(1);
    check("ch2 cnt wrap", cnt(2), 32'h0000_0000);
    cycles(1);
    check("ch2 cnt t3", cnt(2), 32'h0000_0001);
    rd_chk("ch2 status", 8'h20, 32'h0000_0000);
    wr(8'h10, 32'h0);
    rd_chk("ch2 frozen", 8'h12, 32'd3);

    // Ch3: field masking, reserved offsets
    wr(8'h18, 32'hFFFF_FFFA);
    rd_chk("ch3 ctrl mask", 8'h18, 32'h0000_0002);
    wr(8'h19, 32'hFFFF_FFFF);
    rd_chk("ch3 presc ext", 8'h19, 32'h0000_FFFF);
    wr(8'h1B, 32'h89AB_CDEF);
    rd_chk("ch3 cmp", 8'h1B, 32'h89AB_CDEF);
    wr(8'h1D, 32'h0000_1234);
    rd_chk("ch3 rsvd", 8'h1D, 32'h0000_0000);
    wr(8'h18, 32'h0);

    // Pipelined burst to unmapped 0xFF: write, read, write
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 8'hFF;
    bus.i_wb_data = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    check("burst ack0",   DW'(bus.o_wb_ack), 32'd1);
    check("burst stall0", DW'(bus.o_wb_stall), 32'd0);
    bus.i_wb_we = 1'b0;
    @(posedge clk);
    #1;
    check("burst ack1",   DW'(bus.o_wb_ack), 32'd1);
    check("burst stall1", DW'(bus.o_wb_stall), 32'd0);
    check("burst rdata",  bus.o_wb_data, 32'd0);
    bus.i_wb_we = 1'b1;
    @(posedge clk);
    #1;
    check("burst ack2",   DW'(bus.o_wb_ack), 32'd1);
    check("burst stall2", DW'(bus.o_wb_stall), 32'd0);
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    @(posedge clk);
    #1;
    check("burst ack end", DW'(bus.o_wb_ack), 32'd0);

`ifdef WB_TIMER_CAPTURE_EN
    // Ch3 running slowly at COUNT=7, capture input rises
    wr(8'h1A, 32'd7);
    wr(8'h19, 32'd100);
    wr(8'h18, 32'h1);
    @(negedge clk);
    cap = 4'b1000;
    cycles(4);
    rd_chk("cap capt3", 8'h1C, 32'd7);
    rd_chk("cap status", 8'h20, 32'h0000_0080);
    wr(8'h18, 32'h0);
`endif

    // Reset asserted with a request in flight: no ack, state cleared
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 8'h01;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ack", DW'(bus.o_wb_ack), 32'd0);
    check("midrst cnt2", cnt(2), 32'd0);
    rst          = 1'b0;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    rd_chk("midrst presc0", 8'h01, 32'd0);
    rd_chk("midrst cmp3",   8'h1B, 32'hFFFF_FFFF);
    rd_chk("midrst count0", 8'h02, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
